lfsr_checker: RTL and testbench

Receive-side companion to the board's 4-bit LFSR generator: consumes the sampled generator word stream and confirms it follows the expected pseudo-random sequence. A hunt/lock state machine acquires the sequence and flags mismatches. When the machine loses sync, it returns to hunting. The block sits on the generator's `Q` bus, or on a latched copy of it, and drives status LEDs and a debug error counter.

---
 rtl/lfsr_pkg.sv | 8 +
 rtl/lfsr_checker_sat_counter.sv | 13 +
 rtl/lfsr_checker.sv | 62 ++++++
 tb/tb_lfsr_checker.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared LFSR polynomial, width and checker state type.
package lfsr_pkg;
  localparam int LFSR_WIDTH = 4;
  typedef enum logic {HUNT, LOCKED} lfsr_chk_state_t;
  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] q);
    return {q[2:0], q[3] ^ q[2]};
  endfunction
endpackage

// File: rtl/lfsr_checker_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    if (clr) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/lfsr_checker.sv
// lfsr_checker: hunt/lock checker for the 4-bit LFSR stream.
// Define LFSR_CHECKER_STATS_EN to implement err_count/sync_count; otherwise they read 0.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int WIDTH       = LFSR_WIDTH,
  parameter int LOCK_COUNT  = 3,
  parameter int LOSS_THRESH = 2,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic [WIDTH-1:0]     D,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ERR_CNT_W-1:0] sync_count
);
  localparam logic [3:0] run_last  = 4'(LOCK_COUNT - 1);
  localparam logic [3:0] miss_last = 4'(LOSS_THRESH - 1);
  lfsr_chk_state_t state;
  logic [WIDTH-1:0] pred;
  logic [3:0] run, miss;
  logic hit, hunt_hit, lock_now, miss_evt, drop;
  always_comb begin
    hit      = D == pred;
    hunt_hit = EN && state == HUNT && hit && D != '0;
    lock_now = hunt_hit && run == run_last;
    miss_evt = EN && state == LOCKED && !hit;
    drop     = miss_evt && miss == miss_last;
  end
  assign locked = state == LOCKED;
  // Hunting reseeds from the input; once locked the predictor free-runs.
  always_ff @(posedge CLK)
    if (RST) begin
      state <= HUNT;
      pred  <= '0;
      run   <= '0;
      miss  <= '0;
      err   <= 1'b0;
    end else begin
      err <= miss_evt;
      if (EN) begin
        pred  <= (state == HUNT || drop) ? lfsr_next(D) : lfsr_next(pred);
        run   <= (hunt_hit && !lock_now) ? run + 4'd1 : '0;
        miss  <= (miss_evt && !drop) ? miss + 4'd1 : '0;
        state <= lock_now ? LOCKED : drop ? HUNT : state;
      end
    end
`ifdef LFSR_CHECKER_STATS_EN
  sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clk(CLK), .clr(RST), .inc(miss_evt), .count(err_count)
  );
  sat_counter #(.W(ERR_CNT_W)) u_sync_cnt (
    .clk(CLK), .clr(RST), .inc(lock_now), .count(sync_count)
  );
`else
  assign err_count  = '0;
  assign sync_count = '0;
`endif
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: randomized and directed checks of lfsr_checker against a sequence-table model.
module tb_lfsr_checker;
  logic CLK = 1'b0, RST = 1'b1, EN = 1'b0;
  logic [3:0] D = 4'd0;
  logic locked, err, locked2, err2;
  logic [7:0] err_count, sync_count;
  logic [1:0] err_count2, sync_count2;
  int errors = 0, checks = 0;
  always #5 CLK = ~CLK;

  lfsr_checker dut (
    .CLK(CLK), .RST(RST), .EN(EN), .D(D), .locked(locked), .err(err),
    .err_count(err_count), .sync_count(sync_count)
  );
  lfsr_checker #(.ERR_CNT_W(2)) dut_sat (
    .CLK(CLK), .RST(RST), .EN(EN), .D(D), .locked(locked2), .err(err2),
    .err_count(err_count2), .sync_count(sync_count2)
  );

  // The generator's full period, listed once; successor is the next entry.
  int seq[15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};
  bit ml, me;
  int mp, mr, mm, ec, sc;

  function automatic int succ(int v);
    for (int i = 0; i < 15; i++) if (seq[i] == v) return seq[(i + 1) % 15];
    return 0;
  endfunction

  task automatic model(input bit r, input bit en, input int d);
    if (r) begin
      ml = 0; me = 0; mp = 0; mr = 0; mm = 0; ec = 0; sc = 0;
    end else begin
      me = 0;
      if (en && !ml) begin
        if (d == mp && d != 0) begin
          mr++;
          if (mr == 3) begin ml = 1; mr = 0; mm = 0; sc++; end
        end else mr = 0;
        mp = succ(d);
      end else if (en) begin
        if (d == mp) begin
          mm = 0; mp = succ(mp);
        end else begin
          me = 1; ec++; mm++;
          if (mm == 2) begin ml = 0; mr = 0; mm = 0; mp = succ(d); end
          else mp = succ(mp);
        end
      end
    end
  endtask

  function automatic logic [23:0] expv();
    int e8 = 0, s8 = 0, e2 = 0, s2 = 0;
`ifdef LFSR_CHECKER_STATS_EN
    e8 = ec > 255 ? 255 : ec;
    s8 = sc > 255 ? 255 : sc;
    e2 = ec > 3 ? 3 : ec;
    s2 = sc > 3 ? 3 : sc;
`endif
    return {ml, me, 8'(e8), 8'(s8), ml, me, 2'(e2), 2'(s2)};
  endfunction

  function automatic logic [23:0] obs();
    return {locked, err, err_count, sync_count, locked2, err2, err_count2, sync_count2};
  endfunction

  task automatic step(input bit r, input bit en, input int d);
    @(negedge CLK);
    RST = r; EN = en; D = 4'(d);
    @(posedge CLK);
    #1;
    model(r, en, d);
  endtask

  task automatic test_reset;
    step(1, 0, 0);
    step(1, 1, 5);
    checks++;
    if (obs() !== 24'h0) begin
      errors++; $display("FAIL reset outputs=%h exp=%h", obs(), 24'h0);
    end
  endtask

  task automatic test_lock;
    int v[4] = '{1, 2, 4, 9};
    for (int i = 0; i < 4; i++) begin
      step(0, 1, v[i]);
      checks++;
      if (locked !== (i == 3) || err !== 1'b0) begin
        errors++; $display("FAIL lock step%0d locked=%b err=%b exp_locked=%b", i, locked, err, i == 3);
      end
    end
    checks++;
    if (obs() !== expv()) begin
      errors++; $display("FAIL lock_vec got=%h exp=%h", obs(), expv());
    end
  endtask

  task automatic test_single_error;
    int v[4] = '{3, 7, 13, 10};
    for (int i = 0; i < 4; i++) begin
      step(0, 1, v[i]);
      checks++;
      if (err !== (i == 1) || locked !== 1'b1) begin
        errors++; $display("FAIL single_err step%0d err=%b locked=%b exp_err=%b", i, err, locked, i == 1);
      end
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL single_err_vec step%0d got=%h exp=%h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_loss;
    int v[6] = '{0, 15, 5, 11, 7, 15};
    bit el[6] = '{1, 0, 0, 0, 0, 1};
    bit ee[6] = '{1, 1, 0, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      step(0, 1, v[i]);
      checks++;
      if (locked !== el[i] || err !== ee[i]) begin
        errors++; $display("FAIL loss step%0d locked=%b err=%b exp=%b%b", i, locked, err, el[i], ee[i]);
      end
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL loss_vec step%0d got=%h exp=%h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_gaps;
    int v[4] = '{1, 2, 4, 9};
    step(1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0);
      checks++;
      if (locked !== 1'b0 || obs() !== expv()) begin
        errors++; $display("FAIL stuck_zero i=%0d got=%h exp=%h", i, obs(), expv());
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 1, v[i]);
      checks++;
      if (locked !== (i == 3)) begin
        errors++; $display("FAIL gaps_lock i=%0d locked=%b exp=%b", i, locked, i == 3);
      end
      step(0, 0, $urandom_range(0, 15));
      checks++;
      if (err !== 1'b0 || locked !== (i == 3) || obs() !== expv()) begin
        errors++; $display("FAIL gaps_idle i=%0d got=%h exp=%h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_reset_mid_lock;
    int v[4] = '{3, 6, 13, 10};
    step(1, 1, mp);
    checks++;
    if (obs() !== 24'h0) begin
      errors++; $display("FAIL rst_mid got=%h exp=%h", obs(), 24'h0);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 1, v[i]);
      checks++;
      if (locked !== (i == 3) || obs() !== expv()) begin
        errors++; $display("FAIL relock i=%0d got=%h exp=%h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 300; i++) begin
      step(0, 1, mp ^ $urandom_range(1, 15));
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL sat_miss i=%0d got=%h exp=%h", i, obs(), expv());
      end
      step(0, 1, mp);
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL sat_hit i=%0d got=%h exp=%h", i, obs(), expv());
      end
    end
`ifdef LFSR_CHECKER_STATS_EN
    checks++;
    if (err_count2 !== 2'd3 || err_count !== 8'd255) begin
      errors++; $display("FAIL sat_hold cnt2=%0d cnt8=%0d exp=3/255", err_count2, err_count);
    end
`endif
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 1500; i++) begin
      bit r = $urandom_range(0, 199) == 0;
      bit en = $urandom_range(0, 3) != 0;
      int d = $urandom_range(0, 9) < 7 ? mp : int'($urandom_range(0, 15));
      step(r, en, d);
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL random i=%0d got=%h exp=%h", i, obs(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_single_error();
    test_loss();
    test_gaps();
    test_reset_mid_lock();
    test_saturation();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
